image_rotator: RTL and testbench
================================

IMAGE_ROTATOR -- requirements
Module: image_rotator

Interface
REQ-001 The block SHALL have parameter IMG_LOG2, default 10, meaning log2 of the square image side N (N = 2^IMG_LOG2).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning pixel width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, one-cycle request to begin a frame.
REQ-006 The block SHALL have port rot_mode, input, 2, rotation: 0 none, 1 CCW 90, 2 180, 3 CW 90.
REQ-007 The block SHALL have port in_valid, input, 1, input pixel valid.
REQ-008 The block SHALL have port in_ready, output, 1, input pixel accepted when high with in_valid.
REQ-009 The block SHALL have port in_data, input, DATA_W, raster-order input pixel.
REQ-010 The block SHALL have port out_valid, output, 1, output pixel valid.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts the pixel.
REQ-012 The block SHALL have port out_data, output, DATA_W, rotated raster-order output pixel.
REQ-013 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 The block SHALL have port frame_done, output, 1, one-cycle pulse after the last output handshake.

Function
REQ-015 The block SHALL implement FSM states IDLE, LOAD, DRAIN, DONE.
REQ-016 IDLE SHALL go to LOAD on start=1 and latch rot_mode (and mirror, if built) into internal registers; start SHALL be ignored in every other state.
REQ-017 In LOAD, in_ready SHALL be 1; each in_valid&in_ready handshake SHALL write in_data to internal N*N x DATA_W memory at address {y,x}, x incrementing first and wrapping N-1->0 with y+1.
REQ-018 LOAD SHALL go to DRAIN on the cycle after the handshake at (x,y)=(N-1,N-1); in_ready SHALL be 0 in all states except LOAD.
REQ-019 In DRAIN, output counters (r,c) SHALL scan raster order; the memory SHALL be read at source (y,x): mode 0 (r,c); mode 1 (c,N-1-r); mode 2 (N-1-r,N-1-c); mode 3 (N-1-c,r); address = {y,x}.
REQ-020 Memory read SHALL have one-cycle synchronous latency; out_valid SHALL rise no later than 2 cycles after DRAIN entry.
REQ-021 With out_ready held 1, the block SHALL sustain one output pixel per cycle with no bubbles.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable and counters SHALL not advance; no pixel SHALL be dropped or duplicated.
REQ-023 DRAIN SHALL go to DONE after the handshake of output (N-1,N-1); DONE SHALL assert frame_done for exactly one cycle and return to IDLE on the next cycle.
REQ-024 All coordinate arithmetic SHALL be IMG_LOG2 bits wide and wrap modulo N; N-1-v SHALL be computed as bitwise inversion of v.
REQ-025 A start pulse arriving in the same cycle as frame_done SHALL be ignored; a new frame requires start in IDLE.

Reset
REQ-026 On rst_n=0, asynchronously: state IDLE, all counters 0, in_ready 0, out_valid 0, out_data 0, busy 0, frame_done 0.
REQ-027 Reset asserted mid-LOAD or mid-DRAIN SHALL abort the frame; memory contents need not be cleared; the next frame SHALL behave as if the memory were fresh.

Configuration
REQ-028 Macro ROTATOR_MIRROR_EN SHALL, when defined, add input port mirror (1 bit), latched at start; when latched 1, c SHALL be replaced by N-1-c before the REQ-019 mapping.
REQ-029 Without ROTATOR_MIRROR_EN the mirror port SHALL not exist and behaviour SHALL equal mirror=0.

Verification (IMG_LOG2=2, DATA_W=8, input pixel k = k for k=0..15)
REQ-030 mode 0, out_ready=1 -> outputs 0..15 in order, one per cycle, then single frame_done pulse.
REQ-031 mode 1 -> first output row 3,7,11,15; last row 0,4,8,12.
REQ-032 mode 2 -> outputs 15,14,...,0; mode 3 -> first row 12,8,4,0.
REQ-033 mode 1, out_ready toggling 1,0,0,1 repeating -> same 16-value sequence as REQ-031, out_data stable during stalls.
REQ-034 rst_n pulsed low after 7 input handshakes, then full mode-0 frame -> outputs 0..15, busy 0 immediately on reset.
REQ-035 With ROTATOR_MIRROR_EN, mode 0, mirror=1 -> first row 3,2,1,0; start pulsed during DRAIN -> ignored, frame unchanged.

Source files
------------

// File: rtl/image_rotator_if.sv
// rtl/image_rotator_if.sv - pixel input/output handshake bundle for image_rotator
interface image_rotator_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Producer/consumer side (drives input pixels, accepts output pixels)
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Rotator side
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/image_rotator.sv
// rtl/image_rotator.sv - frame-buffered square image rotator (0/90/180/270), optional mirror via ROTATOR_MIRROR_EN
module image_rotator #(
  parameter int IMG_LOG2 = 10,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          rot_mode,
`ifdef ROTATOR_MIRROR_EN
  input  logic                mirror,
`endif
  image_rotator_if.slave      bus,
  output logic                busy,
  output logic                frame_done
);

  localparam int AW    = 2 * IMG_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [IMG_LOG2-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [1:0]          mode_q;
  logic [IMG_LOG2-1:0] x;
  logic [IMG_LOG2-1:0] y;
  logic [IMG_LOG2-1:0] r;
  logic [IMG_LOG2-1:0] c;
  logic                issued_all;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_hs;
  logic                out_hs;
  logic                adv;
  logic [IMG_LOG2-1:0] cm;
  logic [IMG_LOG2-1:0] src_y;
  logic [IMG_LOG2-1:0] src_x;
  logic [AW-1:0]       rd_addr;
  logic [AW-1:0]       wr_addr;

`ifdef ROTATOR_MIRROR_EN
  logic                mirror_q;
`else
  logic                mirror_q;
  assign mirror_q = 1'b0;
`endif

  assign in_hs   = bus.in_valid & bus.in_ready;
  assign out_hs  = bus.out_valid & bus.out_ready;
  // A read is issued only when the output register is empty or being emptied,
  // so a stall freezes both the counters and the presented pixel.
  assign adv     = (state == DRAIN) & ~issued_all & (~bus.out_valid | bus.out_ready);
  assign wr_addr = {y, x};
  assign rd_addr = {src_y, src_x};

  // Map output raster position (r, c) to source pixel (y, x); N-1-v is ~v
  always_comb begin
    cm    = mirror_q ? ~c : c;
    src_y = r;
    src_x = cm;
    case (mode_q)
      2'd0: begin src_y = r;   src_x = cm;  end
      2'd1: begin src_y = cm;  src_x = ~r;  end
      2'd2: begin src_y = ~r;  src_x = ~cm; end
      2'd3: begin src_y = ~cm; src_x = r;   end
      default: begin src_y = r; src_x = cm; end
    endcase
  end

  // Frame buffer write port; contents are never cleared since each frame fully overwrites it
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem[wr_addr] <= bus.in_data;
    end
  end

  // Control FSM with registered handshake/status outputs and the read data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode_q        <= 2'd0;
`ifdef ROTATOR_MIRROR_EN
      mirror_q      <= 1'b0;
`endif
      x             <= '0;
      y             <= '0;
      r             <= '0;
      c             <= '0;
      issued_all    <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            mode_q       <= rot_mode;
`ifdef ROTATOR_MIRROR_EN
            mirror_q     <= mirror;
`endif
            x            <= '0;
            y            <= '0;
            r            <= '0;
            c            <= '0;
            issued_all   <= 1'b0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end

        LOAD: begin
          if (in_hs) begin
            x <= x + 1'b1;
            if (x == CMAX) begin
              y <= y + 1'b1;
            end
            if ((x == CMAX) && (y == CMAX)) begin
              state        <= DRAIN;
              bus.in_ready <= 1'b0;
            end
          end
        end

        DRAIN: begin
          if (adv) begin
            bus.out_data  <= mem[rd_addr];
            bus.out_valid <= 1'b1;
            c             <= c + 1'b1;
            if (c == CMAX) begin
              r <= r + 1'b1;
            end
            if ((c == CMAX) && (r == CMAX)) begin
              issued_all <= 1'b1;
            end
          end else if (out_hs) begin
            bus.out_valid <= 1'b0;
            if (issued_all) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end
        end

        DONE: begin
          state      <= IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
          busy          <= 1'b0;
          frame_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_rotator.sv
// tb/tb_image_rotator.sv - scoreboard bench for image_rotator on a 4x4 frame
module tb_image_rotator;
  localparam int L  = 2;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rot_mode = 2'd0;
  logic       busy;
  logic       frame_done;
`ifdef ROTATOR_MIRROR_EN
  logic       mirror = 1'b0;
`endif

  image_rotator_if #(.DATA_W(DW)) bus ();

  image_rotator #(.IMG_LOG2(L), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rot_mode   (rot_mode),
`ifdef ROTATOR_MIRROR_EN
    .mirror     (mirror),
`endif
    .bus        (bus.slave),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial forever #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q [$];
  logic [7:0] tbl [5][16];
  int         cyc = 0;
  int         fd_cnt = 0;
  int         fd_cyc = 0;
  int         first_valid = 0;
  int         last_in_hs = 0;
  int         pix_cnt = 0;
  bit         first_seen = 0;
  bit         stall_prev = 0;
  logic [7:0] held = '0;
  logic [7:0] mon_e;
  bit [3:0]   rdy_pat = 4'b1111;
  int         rdy_idx = 0;
  bit         start_on_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Downstream ready pattern, cycled every clock
  always @(posedge clk) begin
    #1;
    bus.out_ready = rdy_pat[rdy_idx % 4];
    rdy_idx++;
  end

  // Monitor: pops the scoreboard on every output handshake, checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", {31'd0, bus.out_valid}, 32'd1);
        check("stall_data_held", {24'd0, bus.out_data}, {24'd0, held});
      end
      if (bus.in_valid && bus.in_ready) last_in_hs = cyc;
      if (bus.out_valid && !first_seen) begin
        first_seen  = 1;
        first_valid = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel", {24'd0, bus.out_data}, {24'd0, mon_e});
        end
        pix_cnt++;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
        if (start_on_done) start = 1'b1;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = bus.out_data;
    end
  end

  task automatic feed(input int cnt, input bit gaps);
    bit ok;
    int t;
    for (int k = 0; k < cnt; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = k[7:0];
      ok = 0;
      t  = 0;
      while (!ok && t < 50) begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!ok) check("in_handshake_timeout", 32'd1, 32'd0);
      bus.in_valid = 1'b0;
      if (gaps && k[0]) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic begin_frame(input logic [1:0] mode, input bit mir);
    @(posedge clk);
    #1;
    start    = 1'b1;
    rot_mode = mode;
`ifdef ROTATOR_MIRROR_EN
    mirror   = mir;
`endif
    @(posedge clk);
    #1;
    start    = 1'b0;
    rot_mode = ~mode;
`ifdef ROTATOR_MIRROR_EN
    mirror   = ~mir;
`endif
    check("busy_in_load", {31'd0, busy}, 32'd1);
    check("in_ready_in_load", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_frame(input logic [1:0] mode, input int ti, input bit gaps, input bit mir,
                           input bit drain_start, input bit done_start, input bit chk_bubble);
    int fd0;
    int t;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(tbl[ti][i]);
    fd0        = fd_cnt;
    pix_cnt    = 0;
    first_seen = 0;
    begin_frame(mode, mir);
    feed(16, gaps);
    if (drain_start) begin
      @(posedge clk);
      #1;
      start    = 1'b1;
      rot_mode = mode + 2'd1;
      @(posedge clk);
      #1;
      start    = 1'b0;
    end
    start_on_done = done_start;
    t = 0;
    while (fd_cnt == fd0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check("frame_done_timeout", {31'd0, t < 300}, 32'd1);
    #1;
    start         = 1'b0;
    start_on_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check("frame_done_pulses", fd_cnt - fd0, 32'd1);
    check("pixel_count", pix_cnt, 32'd16);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd0);
    check("out_valid_latency", {31'd0, (first_valid - last_in_hs) <= 3}, 32'd1);
    if (chk_bubble) check("no_bubbles", fd_cyc - first_valid, 32'd16);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tbl[0][i] = i[7:0];
      tbl[2][i] = 8'(15 - i);
    end
    tbl[1] = '{8'd3, 8'd7, 8'd11, 8'd15, 8'd2, 8'd6, 8'd10, 8'd14,
               8'd1, 8'd5, 8'd9, 8'd13, 8'd0, 8'd4, 8'd8, 8'd12};
    tbl[3] = '{8'd12, 8'd8, 8'd4, 8'd0, 8'd13, 8'd9, 8'd5, 8'd1,
               8'd14, 8'd10, 8'd6, 8'd2, 8'd15, 8'd11, 8'd7, 8'd3};
    tbl[4] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd7, 8'd6, 8'd5, 8'd4,
               8'd11, 8'd10, 8'd9, 8'd8, 8'd15, 8'd14, 8'd13, 8'd12};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_out_data", {24'd0, bus.out_data}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;

    rdy_pat = 4'b1111;
    run_frame(2'd0, 0, 0, 0, 0, 0, 1);
    run_frame(2'd1, 1, 0, 0, 0, 0, 1);
    run_frame(2'd2, 2, 1, 0, 1, 0, 1);
    run_frame(2'd3, 3, 0, 0, 0, 1, 1);

    rdy_pat = 4'b1001;
    run_frame(2'd1, 1, 0, 0, 0, 0, 0);
    rdy_pat = 4'b1111;

    begin_frame(2'd2, 0);
    feed(7, 0);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(2'd0, 0, 0, 0, 0, 0, 1);

`ifdef ROTATOR_MIRROR_EN
    run_frame(2'd0, 4, 0, 1, 1, 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
